bluetooth_cmd_ctrl: RTL and testbench

Frame controller that sits directly behind the Bluetooth UART byte receiver. It turns the raw received byte stream into validated command frames of the form header, command, length, payload, optional checksum, and presents each accepted command to the recognition/control logic as a single-cycle strobe. It enforces an inter-byte timeout and a payload length limit, and reports malformed frames with an error code.

---
 rtl/bt_pkg.sv | 21 ++
 rtl/bluetooth_cmd_ctrl_if.sv | 27 ++
 rtl/bt_frame_timer.sv | 26 ++
 rtl/bluetooth_cmd_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bluetooth_cmd_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth command frame controller.
// Contents: frame-parser state encoding, default start-of-frame byte,
// error code constants reported on err_code.
package bt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } bt_state_t;

    localparam logic [7:0] BT_HEADER = 8'hAA;

    localparam logic [1:0] BT_ERR_NONE    = 2'd0;
    localparam logic [1:0] BT_ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] BT_ERR_LEN     = 2'd2;
    localparam logic [1:0] BT_ERR_CSUM    = 2'd3;

endpackage

// File: rtl/bluetooth_cmd_ctrl_if.sv
// Byte-in / command-out bundle of the Bluetooth command frame controller.
// Signals: rx_byte/rx_flag (UART receiver side), cmd_valid/cmd_code/cmd_len/
// cmd_payload (accepted frame), frame_err/err_code (aborted frame), busy.
// Modports: master = byte source and command consumer, slave = controller.
interface bluetooth_cmd_ctrl_if #(
    parameter int unsigned MAX_PAYLOAD = 4
);
    logic [7:0]               rx_byte;
    logic                     rx_flag;
    logic                     cmd_valid;
    logic [7:0]               cmd_code;
    logic [2:0]               cmd_len;
    logic [8*MAX_PAYLOAD-1:0] cmd_payload;
    logic                     frame_err;
    logic [1:0]               err_code;
    logic                     busy;

    modport master (
        output rx_byte, rx_flag,
        input  cmd_valid, cmd_code, cmd_len, cmd_payload, frame_err, err_code, busy
    );

    modport slave (
        input  rx_byte, rx_flag,
        output cmd_valid, cmd_code, cmd_len, cmd_payload, frame_err, err_code, busy
    );
endinterface

// File: rtl/bt_frame_timer.sv
// Inter-byte idle timer for the frame controller.
// Ports: clk, reset (sync, active high), clr (zero the count), run (count
// while high), expire (count has reached TIMEOUT_CYC-1 while running).
module bt_frame_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expire
);
    localparam int unsigned W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = run && (cnt == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/bluetooth_cmd_ctrl.sv
// Bluetooth command frame controller: turns the UART byte stream into
// validated frames HEADER, cmd, len, payload[len], optional checksum.
// Ports: clk, reset (sync, active high), bus (slave modport of
// bluetooth_cmd_ctrl_if: rx_byte/rx_flag in; cmd_*, frame_err, err_code,
// busy out). Optional feature macro: BT_CHECKSUM_EN adds the trailing
// checksum byte (8-bit sum of cmd, len and payload) and error code 3.
module bluetooth_cmd_ctrl
    import bt_pkg::*;
#(
    parameter logic [7:0]  HEADER      = BT_HEADER,
    parameter int unsigned MAX_PAYLOAD = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    bluetooth_cmd_ctrl_if.slave bus
);
    localparam int unsigned PW = 8 * MAX_PAYLOAD;

    bt_state_t       state;
    logic            flag_d;
    logic            evt;
    logic            expire;
    logic            in_frame;
    logic [7:0]      work_cmd;
    logic [2:0]      work_len;
    logic [2:0]      idx;
    logic [PW-1:0]   work_payload;
    logic [PW-1:0]   payload_next;
    logic            cmd_valid_r;
    logic            frame_err_r;
    logic [1:0]      err_code_r;
    logic [7:0]      cmd_code_r;
    logic [2:0]      cmd_len_r;
    logic [PW-1:0]   cmd_payload_r;
`ifdef BT_CHECKSUM_EN
    logic [7:0]      sum;
`endif

    // Rising edge of the receiver flag; flag_d resets high so a flag already
    // asserted at reset release is not taken as a byte.
    assign evt      = bus.rx_flag & ~flag_d;
    assign in_frame = (state != ST_IDLE);

    // Working payload including the byte arriving now, so the last data byte
    // can be published in the same cycle it is stored.
    always_comb begin
        payload_next = work_payload;
        payload_next[{idx, 3'b000} +: 8] = bus.rx_byte;
    end

    bt_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (evt | ~in_frame),
        .run    (in_frame),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            flag_d        <= 1'b1;
            cmd_valid_r   <= 1'b0;
            frame_err_r   <= 1'b0;
            err_code_r    <= BT_ERR_NONE;
            cmd_code_r    <= '0;
            cmd_len_r     <= '0;
            cmd_payload_r <= '0;
            work_cmd      <= '0;
            work_len      <= '0;
            idx           <= '0;
            work_payload  <= '0;
`ifdef BT_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            flag_d      <= bus.rx_flag;
            cmd_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            if (state == ST_IDLE) begin
                if (evt && bus.rx_byte == HEADER) begin
                    state        <= ST_CMD;
                    work_payload <= '0;
                end
            end else if (evt) begin
                // A byte event takes priority over a coincident timeout.
                case (state)
                    ST_CMD: begin
                        work_cmd <= bus.rx_byte;
                        state    <= ST_LEN;
`ifdef BT_CHECKSUM_EN
                        sum      <= bus.rx_byte;
`endif
                    end
                    ST_LEN: begin
                        work_len <= bus.rx_byte[2:0];
                        idx      <= '0;
`ifdef BT_CHECKSUM_EN
                        sum      <= sum + bus.rx_byte;
`endif
                        if (bus.rx_byte > 8'(MAX_PAYLOAD)) begin
                            frame_err_r <= 1'b1;
                            err_code_r  <= BT_ERR_LEN;
                            state       <= ST_IDLE;
                        end else if (bus.rx_byte == 8'd0) begin
`ifdef BT_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            cmd_valid_r   <= 1'b1;
                            cmd_code_r    <= work_cmd;
                            cmd_len_r     <= '0;
                            cmd_payload_r <= work_payload;
                            state         <= ST_IDLE;
`endif
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        work_payload <= payload_next;
                        idx          <= idx + 3'd1;
`ifdef BT_CHECKSUM_EN
                        sum          <= sum + bus.rx_byte;
`endif
                        if (idx == work_len - 3'd1) begin
`ifdef BT_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            cmd_valid_r   <= 1'b1;
                            cmd_code_r    <= work_cmd;
                            cmd_len_r     <= work_len;
                            cmd_payload_r <= payload_next;
                            state         <= ST_IDLE;
`endif
                        end
                    end
`ifdef BT_CHECKSUM_EN
                    ST_CSUM: begin
                        state <= ST_IDLE;
                        if (bus.rx_byte == sum) begin
                            cmd_valid_r   <= 1'b1;
                            cmd_code_r    <= work_cmd;
                            cmd_len_r     <= work_len;
                            cmd_payload_r <= work_payload;
                        end else begin
                            frame_err_r <= 1'b1;
                            err_code_r  <= BT_ERR_CSUM;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end else if (expire) begin
                frame_err_r <= 1'b1;
                err_code_r  <= BT_ERR_TIMEOUT;
                state       <= ST_IDLE;
            end
        end
    end

    assign bus.cmd_valid   = cmd_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.err_code    = err_code_r;
    assign bus.cmd_code    = cmd_code_r;
    assign bus.cmd_len     = cmd_len_r;
    assign bus.cmd_payload = cmd_payload_r;
    assign bus.busy        = in_frame;
endmodule

// File: tb/tb_bluetooth_cmd_ctrl.sv
// Self-checking bench for bluetooth_cmd_ctrl (works with or without
// BT_CHECKSUM_EN): frame table, hand-written corner sequences and random
// frames, all checked every cycle against a byte-queue reference model.
module tb_bluetooth_cmd_ctrl;
    localparam int unsigned MAXP = 4;
    localparam int unsigned T    = 50;
`ifdef BT_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bluetooth_cmd_ctrl_if #(.MAX_PAYLOAD(MAXP)) bus ();

    bluetooth_cmd_ctrl #(
        .HEADER      (8'hAA),
        .MAX_PAYLOAD (MAXP),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int seen_valid;
    int seen_err;

    // Reference model: bytes of the current frame after the header.
    logic [7:0]  fb[$];
    bit          m_flag_prev;
    bit          m_in;
    int          m_since;
    logic        m_valid, m_err;
    logic [1:0]  m_code;
    logic [7:0]  m_cmd;
    logic [2:0]  m_len;
    logic [31:0] m_pay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic judge();
        int n;
        int l;
        logic [7:0] s;
        n = fb.size();
        if (n < 2) return;
        l = int'(fb[1]);
        if (l > int'(MAXP)) begin
            m_err = 1'b1; m_code = 2'd2; m_in = 1'b0;
            return;
        end
        if (n == 2 + l + (CS ? 1 : 0)) begin
            m_in = 1'b0;
            if (CS) begin
                s = 8'd0;
                for (int i = 0; i < n - 1; i++) s = s + fb[i];
                if (s != fb[n-1]) begin
                    m_err = 1'b1; m_code = 2'd3;
                    return;
                end
            end
            m_valid = 1'b1;
            m_cmd   = fb[0];
            m_len   = l[2:0];
            m_pay   = '0;
            for (int i = 0; i < l; i++) m_pay[8*i +: 8] = fb[2+i];
        end
    endtask

    task automatic model_step();
        bit evt;
        if (reset) begin
            m_flag_prev = 1'b1; m_in = 1'b0; fb.delete(); m_since = 0;
            m_valid = 0; m_err = 0; m_code = 0; m_cmd = 0; m_len = 0; m_pay = 0;
            return;
        end
        evt = bus.rx_flag && !m_flag_prev;
        m_flag_prev = bus.rx_flag;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!m_in) begin
            if (evt && bus.rx_byte == 8'hAA) begin
                m_in = 1'b1; fb.delete(); m_since = 0;
            end
        end else if (evt) begin
            m_since = 0;
            fb.push_back(bus.rx_byte);
            judge();
        end else begin
            m_since++;
            if (m_since >= int'(T)) begin
                m_err = 1'b1; m_code = 2'd1; m_in = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cmd_valid",   32'(bus.cmd_valid), 32'(m_valid));
        check("frame_err",   32'(bus.frame_err), 32'(m_err));
        check("err_code",    32'(bus.err_code),  32'(m_code));
        check("cmd_code",    32'(bus.cmd_code),  32'(m_cmd));
        check("cmd_len",     32'(bus.cmd_len),   32'(m_len));
        check("cmd_payload", bus.cmd_payload,    m_pay);
        check("busy",        32'(bus.busy),      32'(m_in));
        if (bus.cmd_valid === 1'b1) seen_valid++;
        if (bus.frame_err === 1'b1) seen_err++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        bus.rx_byte = b;
        bus.rx_flag = 1'b1;
        repeat (hold) tick();
        bus.rx_flag = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [79:0] bytes;
        int          n;
        int          ev;
        int          ee;
        logic [1:0]  ec;
        logic [7:0]  code;
        logic [2:0]  len;
        logic [31:0] pay;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] c, input logic [7:0] l, input int nd,
                       input logic [31:0] d, input logic [7:0] cs_delta,
                       input int ev, input int ee, input logic [1:0] ec,
                       input logic [7:0] code, input logic [2:0] len, input logic [31:0] pay);
        vec_t v;
        logic [7:0] s;
        v.bytes = '0;
        v.bytes[0 +: 8]  = 8'hAA;
        v.bytes[8 +: 8]  = c;
        v.bytes[16 +: 8] = l;
        v.n = 3;
        s = c + l;
        for (int i = 0; i < nd; i++) begin
            v.bytes[8*v.n +: 8] = d[8*i +: 8];
            s = s + d[8*i +: 8];
            v.n++;
        end
        if (CS && l <= 8'(MAXP)) begin
            v.bytes[8*v.n +: 8] = s + cs_delta;
            v.n++;
        end
        v.ev = ev; v.ee = ee; v.ec = ec; v.code = code; v.len = len; v.pay = pay;
        tbl.push_back(v);
    endtask

    task automatic expect_after(input string name, input int ev, input int ee, input logic [1:0] ec,
                                input logic [7:0] code, input logic [2:0] len, input logic [31:0] pay);
        check({name, " valid_count"}, 32'(seen_valid), 32'(ev));
        check({name, " err_count"},   32'(seen_err),   32'(ee));
        check({name, " err_code"},    32'(bus.err_code), 32'(ec));
        check({name, " cmd_code"},    32'(bus.cmd_code), 32'(code));
        check({name, " cmd_len"},     32'(bus.cmd_len),  32'(len));
        check({name, " payload"},     bus.cmd_payload,   pay);
        check({name, " busy"},        32'(bus.busy),     32'd0);
    endtask

    logic [7:0] rq[$];
    logic [7:0] rs;
    int         rl;

    initial begin
        // Reset with flag already high: must not count as a byte afterwards.
        reset = 1'b1;
        bus.rx_flag = 1'b1;
        bus.rx_byte = 8'hAA;
        repeat (3) tick();
        expect_after("reset", 0, 0, 2'd0, 8'h00, 3'd0, 32'h0);
        reset = 1'b0;
        repeat (4) tick();
        check("flag_high_at_release busy", 32'(bus.busy), 32'd0);
        bus.rx_flag = 1'b0;
        tick();

        add(8'h01, 8'h02, 2, 32'h0000_2010, 8'd0, 1, 0, 2'd0, 8'h01, 3'd2, 32'h0000_2010);
        if (CS)
            add(8'h01, 8'h02, 2, 32'h0000_2010, 8'd1, 0, 1, 2'd3, 8'h01, 3'd2, 32'h0000_2010);
        add(8'h05, 8'h06, 0, 32'h0, 8'd0, 0, 1, 2'd2, 8'h01, 3'd2, 32'h0000_2010);
        add(8'h07, 8'h00, 0, 32'h0, 8'd0, 1, 0, 2'd2, 8'h07, 3'd0, 32'h0);
        add(8'hAA, 8'h04, 4, 32'h0302_01AA, 8'd0, 1, 0, 2'd2, 8'hAA, 3'd4, 32'h0302_01AA);
        add(8'h09, 8'h05, 0, 32'h0, 8'd0, 0, 1, 2'd2, 8'hAA, 3'd4, 32'h0302_01AA);
        add(8'h11, 8'h01, 1, 32'h0000_005A, 8'd0, 1, 0, 2'd2, 8'h11, 3'd1, 32'h0000_005A);
        add(8'hFF, 8'h03, 3, 32'h00C0_B0A0, 8'd0, 1, 0, 2'd2, 8'hFF, 3'd3, 32'h00C0_B0A0);

        foreach (tbl[k]) begin
            seen_valid = 0; seen_err = 0;
            for (int i = 0; i < tbl[k].n; i++) send_byte(tbl[k].bytes[8*i +: 8], 1);
            tick(); tick();
            expect_after($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ee, tbl[k].ec,
                         tbl[k].code, tbl[k].len, tbl[k].pay);
        end

        // Timeout after the command byte.
        seen_valid = 0; seen_err = 0;
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        repeat (T + 5) tick();
        expect_after("timeout", 0, 1, 2'd1, 8'hFF, 3'd3, 32'h00C0_B0A0);

        // Byte arrives exactly on the expiry cycle: the byte wins.
        seen_valid = 0; seen_err = 0;
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        repeat (T - 2) tick();
        send_byte(8'h00, 1);
        if (CS) send_byte(8'h01, 1);
        tick();
        expect_after("expiry_race", 1, 0, 2'd1, 8'h01, 3'd0, 32'h0);

        // Long-held flags, garbage before the header.
        seen_valid = 0; seen_err = 0;
        send_byte(8'h55, 1000);
        send_byte(8'hAB, 1000);
        send_byte(8'hAA, T - 10);
        send_byte(8'h02, T - 10);
        if (CS) begin
            send_byte(8'h00, T - 10);
            send_byte(8'h02, 1000);
        end else begin
            send_byte(8'h00, 1000);
        end
        expect_after("held_flag", 1, 0, 2'd1, 8'h02, 3'd0, 32'h0);

        // Reset mid-frame discards it silently.
        seen_valid = 0; seen_err = 0;
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        send_byte(8'h01, 1);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        expect_after("mid_reset", 0, 0, 2'd0, 8'h00, 3'd0, 32'h0);
        send_byte(8'hAA, 1);
        send_byte(8'h03, 1);
        send_byte(8'h00, 1);
        if (CS) send_byte(8'h03, 1);
        tick();
        expect_after("after_reset", 1, 0, 2'd0, 8'h03, 3'd0, 32'h0);

        // Random frames with occasional errors, garbage and long gaps.
        for (int f = 0; f < 80; f++) begin
            rq.delete();
            if ($urandom_range(0, 4) == 0) rq.push_back(8'($urandom));
            rq.push_back(8'hAA);
            rs = 8'($urandom);
            rq.push_back(rs);
            rl = $urandom_range(0, 6);
            rq.push_back(8'(rl));
            rs = rs + 8'(rl);
            for (int i = 0; i < rl; i++) begin
                rq.push_back(8'($urandom));
                rs = rs + rq[rq.size()-1];
            end
            if (CS) rq.push_back(($urandom_range(0, 4) == 0) ? rs + 8'd1 : rs);
            foreach (rq[i]) begin
                send_byte(rq[i], $urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) repeat ($urandom_range(40, 60)) tick();
                else repeat ($urandom_range(0, 2)) tick();
            end
        end
        repeat (T + 5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
